ysyx_25040109_lsu: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the execute stage. It takes the execute result (effective address or ALU value), the store data and the destination-register info through a valid/ready handshake. For loads and stores it runs one transaction on a simple request/response memory bus, with byte-lane alignment, sign/zero extension and a response timeout. Every instruction, memory or not, is then forwarded to write-back through a second valid/ready handshake.

---
 rtl/ysyx_25040109_lsu_pkg.sv | 27 ++
 rtl/ysyx_25040109_lsu_align.sv | 42 ++++
 rtl/ysyx_25040109_lsu.sv | 188 ++++++++++++++++++
 tb/tb_ysyx_25040109_lsu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25040109_lsu_pkg.sv
// Shared constants and types for the ysyx_25040109 load/store unit.
// Holds the opcode and funct3 codes, the FSM state type and the byte-lane mask width.
package ysyx_25040109_lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size is funct3[1:0]; 10 and 11 both behave as a word access.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;

    localparam int unsigned MASK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Combinational byte-lane alignment: store lane masks/replication, load shift and
// sign/zero extension, and the misalignment check for the access width.
module ysyx_25040109_LSU_align
    import ysyx_25040109_lsu_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    output logic [MASK_W-1:0] wmask,
    output logic [31:0]       lane_wdata,
    output logic [31:0]       load_data,
    output logic              misalign
);

    logic [31:0] shifted;

    always_comb begin
        shifted    = rdata >> {off, 3'b000};
        wmask      = 4'b1111;
        lane_wdata = wdata;
        load_data  = shifted;
        misalign   = |off;
        // funct3[2] selects zero extension; unsupported codes fall into the word case
        case (funct3[1:0])
            SZ_B: begin
                wmask      = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
                misalign   = 1'b0;
            end
            SZ_H: begin
                wmask      = 4'b0011 << off;
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
                misalign   = off[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Multi-cycle load/store unit: accepts one instruction, runs at most one memory
// transaction with a response timeout, then hands the result to write-back.
module ysyx_25040109_lsu
    import ysyx_25040109_lsu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_result,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_we,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [31:0]       mem_req_addr,
    output logic              mem_req_wen,
    output logic [31:0]       mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata,
    output logic              mem_resp_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [4:0]        out_rd,
    output logic              out_reg_we,
    output logic              out_misalign,
    output logic              out_fault
);

    lsu_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_load_q, is_load_d;
    logic        is_store_q, is_store_d;
    logic [31:0] out_result_q, out_result_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic        out_reg_we_q, out_reg_we_d;
    logic        out_misalign_q, out_misalign_d;
    logic        out_fault_q, out_fault_d;

    logic [2:0]        al_funct3;
    logic [1:0]        al_off;
    logic [MASK_W-1:0] al_wmask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;
    logic              al_misalign;
    logic              in_is_load;
    logic              in_is_store;

    // In IDLE the aligner checks the incoming instruction; afterwards it serves the latched one.
    assign al_funct3   = (state_q == ST_IDLE) ? in_funct3 : f3_q;
    assign al_off      = (state_q == ST_IDLE) ? in_result[1:0] : addr_q[1:0];
    assign in_is_load  = (in_opcode == OP_LOAD);
    assign in_is_store = (in_opcode == OP_STORE);

    ysyx_25040109_LSU_align u_align (
        .funct3     (al_funct3),
        .off        (al_off),
        .wdata      (wdata_q),
        .rdata      (mem_resp_rdata),
        .wmask      (al_wmask),
        .lane_wdata (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            f3_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            is_load_q      <= 1'b0;
            is_store_q     <= 1'b0;
            out_result_q   <= '0;
            out_rd_q       <= '0;
            out_reg_we_q   <= 1'b0;
            out_misalign_q <= 1'b0;
            out_fault_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            f3_q           <= f3_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            is_load_q      <= is_load_d;
            is_store_q     <= is_store_d;
            out_result_q   <= out_result_d;
            out_rd_q       <= out_rd_d;
            out_reg_we_q   <= out_reg_we_d;
            out_misalign_q <= out_misalign_d;
            out_fault_q    <= out_fault_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        is_load_d      = is_load_q;
        is_store_d     = is_store_q;
        out_result_d   = out_result_q;
        out_rd_d       = out_rd_q;
        out_reg_we_d   = out_reg_we_q;
        out_misalign_d = out_misalign_q;
        out_fault_d    = out_fault_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    f3_d           = in_funct3;
                    addr_d         = in_result;
                    wdata_d        = in_wdata;
                    is_load_d      = in_is_load;
                    is_store_d     = in_is_store;
                    out_result_d   = in_result;
                    out_rd_d       = in_rd;
                    out_misalign_d = 1'b0;
                    out_fault_d    = 1'b0;
                    if (!(in_is_load || in_is_store)) begin
                        out_reg_we_d = in_reg_we;
                        state_d      = ST_DONE;
                    end else if (al_misalign) begin
                        out_reg_we_d   = 1'b0;
                        out_misalign_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        out_reg_we_d = in_is_load & in_reg_we;
                        state_d      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A response in the same cycle the count expires takes priority over the fault
                if (mem_resp_valid) begin
                    if (is_load_q) begin
                        out_result_d = al_load;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(MEM_TIMEOUT)) begin
                        out_fault_d  = 1'b1;
                        out_reg_we_d = 1'b0;
                        state_d      = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready       = (state_q == ST_IDLE);
    assign mem_req_valid  = (state_q == ST_REQ);
    assign mem_req_addr   = {addr_q[31:2], 2'b00};
    assign mem_req_wen    = is_store_q;
    assign mem_req_wdata  = al_wdata;
    assign mem_req_wmask  = is_store_q ? al_wmask : '0;
    assign mem_resp_ready = (state_q == ST_WAIT);
    assign out_valid      = (state_q == ST_DONE);
    assign out_result     = out_result_q;
    assign out_rd         = out_rd_q;
    assign out_reg_we     = out_reg_we_q;
    assign out_misalign   = out_misalign_q;
    assign out_fault      = out_fault_q;

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed self-checking bench for ysyx_25040109_lsu with MEM_TIMEOUT=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ysyx_25040109_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic        mem_resp_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_misalign;
    logic        out_fault;

    int total;
    int bad;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    ysyx_25040109_lsu #(.MEM_TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_opcode      (in_opcode),
        .in_funct3      (in_funct3),
        .in_result      (in_result),
        .in_wdata       (in_wdata),
        .in_rd          (in_rd),
        .in_reg_we      (in_reg_we),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_ready (mem_resp_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_reg_we     (out_reg_we),
        .out_misalign   (out_misalign),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                           input logic [31:0] wd, input logic [4:0] rd, input logic we);
        in_opcode = op; in_funct3 = f3; in_result = res; in_wdata = wd; in_rd = rd; in_reg_we = we;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", mem_req_valid); end
        total++; if (mem_resp_ready !== 1'b0) begin bad++; $display("FAIL reset_resp_ready got=%b want=0", mem_resp_ready); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        total++; if (out_rd !== 5'd0) begin bad++; $display("FAIL reset_out_rd got=%0d want=0", out_rd); end
        total++; if ({out_reg_we, out_misalign, out_fault} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {out_reg_we, out_misalign, out_fault}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        out_ready = 1'b1;
        present(OPC_ALU, 3'b000, 32'h0000_1234, 32'hFFFF_FFFF, 5'd5, 1'b1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_valid got=%b want=1", out_valid); end
        total++; if (out_result !== 32'h0000_1234) begin bad++; $display("FAIL pass_result got=%h want=00001234", out_result); end
        total++; if (out_rd !== 5'd5 || out_reg_we !== 1'b1) begin bad++; $display("FAIL pass_rd_we got=%0d/%b want=5/1", out_rd, out_reg_we); end
        total++; if (mem_req_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL pass_no_req got=%b/%b want=0/0", mem_req_valid, in_ready); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL pass_return got=%b/%b want=1/0", in_ready, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [31:0] exp_data);
        out_ready = 1'b0;
        present(OPC_LOAD, f3, addr, 32'h5555_5555, 5'd9, 1'b1);
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) begin bad++; $display("FAIL %s_req got=%b/%h want=1/%h", name, mem_req_valid, mem_req_addr, exp_addr); end
        total++; if (mem_req_wen !== 1'b0 || mem_req_wmask !== 4'b0000) begin bad++; $display("FAIL %s_rdreq got=%b/%b want=0/0000", name, mem_req_wen, mem_req_wmask); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        total++; if (mem_resp_ready !== 1'b1 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL %s_wait got=%b/%b want=1/0", name, mem_resp_ready, mem_req_valid); end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdata;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_result !== exp_data) begin bad++; $display("FAIL %s_data got=%b/%h want=1/%h", name, out_valid, out_result, exp_data); end
        total++; if (out_reg_we !== 1'b1 || out_fault !== 1'b0 || out_rd !== 5'd9) begin bad++; $display("FAIL %s_flags got=%b/%b/%0d want=1/0/9", name, out_reg_we, out_fault, out_rd); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_idle got=%b want=1", name, in_ready); end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_addr,
                              input logic [3:0] exp_mask, input logic [31:0] exp_wdata);
        out_ready = 1'b0;
        present(OPC_STORE, f3, addr, wd, 5'd3, 1'b1);
        total++; if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 || mem_req_addr !== exp_addr) begin bad++; $display("FAIL %s_req got=%b/%b/%h want=1/1/%h", name, mem_req_valid, mem_req_wen, mem_req_addr, exp_addr); end
        total++; if (mem_req_wmask !== exp_mask || mem_req_wdata !== exp_wdata) begin bad++; $display("FAIL %s_lanes got=%b/%h want=%b/%h", name, mem_req_wmask, mem_req_wdata, exp_mask, exp_wdata); end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_reg_we !== 1'b0 || out_result !== addr) begin bad++; $display("FAIL %s_done got=%b/%b/%h want=1/0/%h", name, out_valid, out_reg_we, out_result, addr); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_misalign(input string name, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr);
        out_ready = 1'b0;
        present(op, f3, addr, 32'h0, 5'd7, 1'b1);
        total++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL %s_nobus got=%b/%b want=0/1", name, mem_req_valid, out_valid); end
        total++; if (out_misalign !== 1'b1 || out_reg_we !== 1'b0) begin bad++; $display("FAIL %s_flags got=%b/%b want=1/0", name, out_misalign, out_reg_we); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Enters WAIT with an aligned LW, then either lets the 4-cycle budget run out or answers on its last cycle.
    task automatic test_timeout(input logic answer_last);
        out_ready = 1'b0;
        present(OPC_LOAD, 3'b010, 32'h8000_0010, 32'h0, 5'd4, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (mem_resp_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL to_wait%0d got=%b/%b want=1/0", i, mem_resp_ready, out_valid); end
            if (answer_last && i == 3) begin
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 32'h1122_3344;
            end
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        if (answer_last) begin
            total++; if (out_valid !== 1'b1 || out_fault !== 1'b0 || out_result !== 32'h1122_3344 || out_reg_we !== 1'b1) begin bad++; $display("FAIL to_late_resp got=%b/%b/%h/%b want=1/0/11223344/1", out_valid, out_fault, out_result, out_reg_we); end
        end else begin
            total++; if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_reg_we !== 1'b0) begin bad++; $display("FAIL to_fault got=%b/%b/%b want=1/1/0", out_valid, out_fault, out_reg_we); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        present(OPC_ALU, 3'b000, 32'hCAFE_0001, 32'h0, 5'd12, 1'b1);
        in_opcode = OPC_ALU; in_result = 32'h0BAD_0BAD; in_rd = 5'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 32'hCAFE_0001 || out_rd !== 5'd12) begin bad++; $display("FAIL hold%0d got=%b/%b/%h/%0d want=1/0/cafe0001/12", i, out_valid, in_ready, out_result, out_rd); end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b/%b want=1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        present(OPC_LOAD, 3'b010, 32'h8000_0020, 32'h0, 5'd6, 1'b1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mem_resp_ready !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b/%b/%b want=1/0/0", in_ready, out_valid, mem_resp_ready); end
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_DEAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL rstmid_stale%0d got=%b/%b/%b want=0/1/0", i, out_valid, in_ready, mem_req_valid); end
        end
        mem_resp_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_result = '0;
        in_wdata = '0; in_rd = '0; in_reg_we = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b0;
        test_reset();
        test_passthrough();
        test_load("lb",   3'b000, 32'h8000_0003, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_FF80);
        test_load("lbu",  3'b100, 32'h8000_0003, 32'h80FF_0000, 32'h8000_0000, 32'h0000_0080);
        test_load("lh",   3'b001, 32'h8000_0002, 32'h80FF_0000, 32'h8000_0000, 32'hFFFF_80FF);
        test_load("lhu",  3'b101, 32'h8000_0002, 32'h80FF_0000, 32'h8000_0000, 32'h0000_80FF);
        test_load("lb0",  3'b000, 32'h8000_0104, 32'h1234_567F, 32'h8000_0104, 32'h0000_007F);
        test_load("lw",   3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);
        test_load("f3_6", 3'b110, 32'h8000_0008, 32'h8765_4321, 32'h8000_0008, 32'h8765_4321);
        test_store("sh", 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h8000_0000, 4'b1100, 32'hABCD_ABCD);
        test_store("sb", 3'b000, 32'h8000_0001, 32'h0000_005A, 32'h8000_0000, 4'b0010, 32'h5A5A_5A5A);
        test_store("sw", 3'b010, 32'h8000_0008, 32'h0102_0304, 32'h8000_0008, 4'b1111, 32'h0102_0304);
        test_misalign("lw_mis", OPC_LOAD,  3'b010, 32'h8000_0001);
        test_misalign("sh_mis", OPC_STORE, 3'b001, 32'h8000_0003);
        test_misalign("lhu_mis", OPC_LOAD, 3'b101, 32'h8000_0001);
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
